// File: rtl/dcache_victim_buffer.sv
// rtl/dcache_victim_buffer.sv - write-back victim buffer between DCache and the switch data-write port
module dcache_victim_buffer #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         vb_push_i,
    input  logic [31:0]  vb_addr_i,
    input  logic [255:0] vb_data_i,
    output logic         vb_full_o,
    output logic         vb_empty_o,
    input  logic [31:0]  lk_addr_i,
    output logic         lk_hit_o,
    output logic [255:0] lk_data_o,
    output logic         d_wr_req_o,
    output logic [2:0]   d_wr_type_o,
    output logic [31:0]  d_wr_addr_o,
    output logic [3:0]   d_wr_wstrb_o,
    output logic [255:0] d_wr_data_o,
    input  logic         d_wr_finish_i
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t         state;
    state_t         state_next;
    logic [DEPTH-1:0] valid;
    logic [26:0]    tag  [DEPTH];
    logic [255:0]   line [DEPTH];
    logic [AW-1:0]  hd;
    logic [AW-1:0]  tl;
    logic [AW:0]    cnt;
    logic [AW:0]    cnt_next;
    logic           full_q;
    logic           empty_q;

    logic           busy;
    logic           pop;
    logic           co_hit;
    logic [AW-1:0]  co_idx;
    logic           do_coalesce;
    logic           do_append;
    logic           lk_found;
    logic [AW-1:0]  lk_idx;

    // Address offset bits are don't-care on both the push and lookup ports.
    logic unused_low;
    assign unused_low = ^{vb_addr_i[4:0], lk_addr_i[4:0]};

    assign busy = (state == S_BUSY);
    assign pop  = busy && d_wr_finish_i;

    // Find an entry a push may merge into; the draining head is off limits.
    always_comb begin
        co_hit = 1'b0;
        co_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (tag[i] == vb_addr_i[31:5]) && !(busy && (AW'(i) == hd))) begin
                co_hit = 1'b1;
                co_idx = AW'(i);
            end
        end
    end

    assign do_coalesce = vb_push_i && co_hit;
    assign do_append   = vb_push_i && !co_hit && !full_q;

    // Lookup match; a newer non-head copy takes priority over a draining head.
    always_comb begin
        lk_found = 1'b0;
        lk_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (tag[i] == lk_addr_i[31:5]) && (!lk_found || (AW'(i) != hd))) begin
                lk_found = 1'b1;
                lk_idx   = AW'(i);
            end
        end
    end

    assign lk_hit_o  = lk_found;
    assign lk_data_o = lk_found ? line[lk_idx] : 256'd0;

    // Occupancy after this edge: append and pop cancel each other.
    always_comb begin
        cnt_next = cnt;
        if (do_append && !pop) begin
            cnt_next = cnt + CNT_ONE;
        end else if (!do_append && pop) begin
            cnt_next = cnt - CNT_ONE;
        end
    end

    // Pointers, valid bits and registered flags.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid   <= '0;
            hd      <= '0;
            tl      <= '0;
            cnt     <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (pop) begin
                valid[hd] <= 1'b0;
                hd        <= hd + PTR_ONE;
            end
            if (do_append) begin
                valid[tl] <= 1'b1;
                tl        <= tl + PTR_ONE;
            end
            cnt     <= cnt_next;
            full_q  <= (cnt_next == DEPTH_CNT);
            empty_q <= (cnt_next == '0);
        end
    end

    // Line storage; contents are qualified by valid so they need no reset.
    always_ff @(posedge clk) begin
        if (do_append) begin
            tag[tl]  <= vb_addr_i[31:5];
            line[tl] <= vb_data_i;
        end
        if (do_coalesce) begin
            line[co_idx] <= vb_data_i;
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Drain FSM next state: start when anything is queued, return to idle on finish.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (cnt != '0) state_next = S_BUSY;
            S_BUSY: if (d_wr_finish_i) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Drain FSM outputs: present the head line only while a transfer is active.
    always_comb begin
        d_wr_req_o   = busy;
        d_wr_type_o  = 3'b100;
        d_wr_wstrb_o = 4'hF;
        d_wr_addr_o  = 32'd0;
        d_wr_data_o  = 256'd0;
        if (busy) begin
            d_wr_addr_o = {tag[hd], 5'b0};
            d_wr_data_o = line[hd];
        end
    end

    assign vb_full_o  = full_q;
    assign vb_empty_o = empty_q;

endmodule

// File: tb/tb_dcache_victim_buffer.sv
// tb/tb_dcache_victim_buffer.sv - randomized self-checking bench for dcache_victim_buffer
module tb_dcache_victim_buffer;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         resetn;
    logic         vb_push_i;
    logic [31:0]  vb_addr_i;
    logic [255:0] vb_data_i;
    logic         vb_full_o;
    logic         vb_empty_o;
    logic [31:0]  lk_addr_i;
    logic         lk_hit_o;
    logic [255:0] lk_data_o;
    logic         d_wr_req_o;
    logic [2:0]   d_wr_type_o;
    logic [31:0]  d_wr_addr_o;
    logic [3:0]   d_wr_wstrb_o;
    logic [255:0] d_wr_data_o;
    logic         d_wr_finish_i;

    always #5 clk = ~clk;

    dcache_victim_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .vb_push_i     (vb_push_i),
        .vb_addr_i     (vb_addr_i),
        .vb_data_i     (vb_data_i),
        .vb_full_o     (vb_full_o),
        .vb_empty_o    (vb_empty_o),
        .lk_addr_i     (lk_addr_i),
        .lk_hit_o      (lk_hit_o),
        .lk_data_o     (lk_data_o),
        .d_wr_req_o    (d_wr_req_o),
        .d_wr_type_o   (d_wr_type_o),
        .d_wr_addr_o   (d_wr_addr_o),
        .d_wr_wstrb_o  (d_wr_wstrb_o),
        .d_wr_data_o   (d_wr_data_o),
        .d_wr_finish_i (d_wr_finish_i)
    );

    typedef struct {
        logic [26:0]  tag;
        logic [255:0] data;
    } ent_t;

    // Reference model: an ordered queue of lines (index 0 = oldest) plus a drain-active flag.
    ent_t q[$];
    bit   m_busy;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic compare_outputs(input logic [31:0] la);
        logic         e_hit;
        logic [255:0] e_data;
        e_hit  = 1'b0;
        e_data = '0;
        foreach (q[j]) begin
            if (q[j].tag == la[31:5]) begin
                e_hit  = 1'b1;
                e_data = q[j].data;
            end
        end
        check("full",  {255'd0, vb_full_o},  {255'd0, (q.size() == DEPTH)});
        check("empty", {255'd0, vb_empty_o}, {255'd0, (q.size() == 0)});
        check("req",   {255'd0, d_wr_req_o}, {255'd0, m_busy});
        check("type",  {253'd0, d_wr_type_o}, 256'd4);
        check("wstrb", {252'd0, d_wr_wstrb_o}, 256'hF);
        check("waddr", {224'd0, d_wr_addr_o}, m_busy ? {224'd0, q[0].tag, 5'b0} : 256'd0);
        check("wdata", d_wr_data_o, m_busy ? q[0].data : 256'd0);
        check("lk_hit", {255'd0, lk_hit_o}, {255'd0, e_hit});
        check("lk_data", lk_data_o, e_data);
    endtask

    task automatic model_step(input bit rst, input bit push, input logic [31:0] a,
                              input logic [255:0] d, input bit fin);
        int   n;
        bit   was_busy;
        bit   co;
        ent_t e;
        if (rst) begin
            q.delete();
            m_busy = 1'b0;
        end else begin
            n        = q.size();
            was_busy = m_busy;
            co       = 1'b0;
            if (push) begin
                for (int j = (was_busy ? 1 : 0); j < n; j++) begin
                    if (q[j].tag == a[31:5]) begin
                        e      = q[j];
                        e.data = d;
                        q[j]   = e;
                        co     = 1'b1;
                    end
                end
                if (!co && n < DEPTH) begin
                    e.tag  = a[31:5];
                    e.data = d;
                    q.push_back(e);
                end
            end
            if (was_busy && fin) begin
                void'(q.pop_front());
                m_busy = 1'b0;
            end else if (!was_busy && n != 0) begin
                m_busy = 1'b1;
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit push, input logic [31:0] a,
                         input logic [255:0] d, input bit fin, input logic [31:0] la);
        resetn        = !rst;
        vb_push_i     = push;
        vb_addr_i     = a;
        vb_data_i     = d;
        d_wr_finish_i = fin;
        lk_addr_i     = la;
        @(negedge clk);
        compare_outputs(la);
        @(posedge clk);
        model_step(rst, push, a, d, fin);
        #1;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] v;
        v = 32'h1000_0000 + ($urandom_range(0, 5) << 5) + $urandom_range(0, 31);
        return v;
    endfunction

    logic [255:0] d1;
    logic [255:0] d2;

    initial begin
        d1 = {8{32'hA5A5_0001}};
        d2 = {8{32'h5A5A_0002}};

        // reset held for two edges
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);

        // single line: push, lookup with offset bits set, drain with finish at T+5
        cycle(0, 1, 32'h1000_0040, d1, 0, 32'h1000_005C);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 0, 32'h1000_005C);
        cycle(0, 0, 0, 0, 1, 32'h1000_005C);
        cycle(0, 0, 0, 0, 0, 32'h1000_005C);

        // fill to full, third push dropped, drain both
        cycle(0, 1, 32'h100, rand_line(), 0, 32'h100);
        cycle(0, 1, 32'h200, rand_line(), 0, 32'h200);
        cycle(0, 1, 32'h300, rand_line(), 0, 32'h300);
        cycle(0, 0, 0, 0, 1, 32'h300);
        cycle(0, 0, 0, 0, 0, 32'h200);
        cycle(0, 0, 0, 0, 1, 32'h200);
        cycle(0, 0, 0, 0, 0, 32'h100);

        // coalesce into non-head while head drains
        cycle(0, 1, 32'h100, rand_line(), 0, 32'h100);
        cycle(0, 1, 32'h200, rand_line(), 0, 32'h200);
        cycle(0, 1, 32'h200, d2, 0, 32'h200);
        cycle(0, 0, 0, 0, 1, 32'h200);
        cycle(0, 0, 0, 0, 0, 32'h200);
        cycle(0, 0, 0, 0, 1, 32'h200);
        cycle(0, 0, 0, 0, 0, 32'h200);

        // duplicate of the draining head is appended and wins lookup
        cycle(0, 1, 32'h100, d1, 0, 32'h100);
        cycle(0, 0, 0, 0, 0, 32'h100);
        cycle(0, 1, 32'h100, d2, 0, 32'h100);
        cycle(0, 0, 0, 0, 0, 32'h100);
        cycle(0, 0, 0, 0, 1, 32'h100);
        cycle(0, 0, 0, 0, 0, 32'h100);
        cycle(0, 0, 0, 0, 1, 32'h100);

        // simultaneous pop and push with one entry queued
        cycle(0, 1, 32'h300, rand_line(), 0, 32'h300);
        cycle(0, 0, 0, 0, 0, 32'h300);
        cycle(0, 1, 32'h400, rand_line(), 1, 32'h400);
        cycle(0, 0, 0, 0, 0, 32'h400);
        cycle(0, 0, 0, 0, 0, 32'h400);

        // reset with two entries queued and a transfer in flight
        cycle(0, 1, 32'h500, rand_line(), 0, 32'h400);
        cycle(1, 0, 0, 0, 0, 32'h400);
        cycle(0, 0, 0, 0, 0, 32'h500);
        cycle(0, 0, 0, 0, 0, 32'h400);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), rand_addr(),
                  rand_line(), ($urandom_range(0, 2) == 0), rand_addr());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
